// File: rtl/adc_sample_link_pkg.sv
// adc_sample_link shared definitions: frame layout,
// field positions and link FSM encoding.
package adc_sample_link_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W   = 10;
  localparam int CHAN_W     = 4;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CHAN_W-1:0] CHAN_NODATA = 4'hF;

  localparam int TAG_MSB = 15;
  localparam int TAG_LSB = 12;
  localparam int SMP_MSB = 9;
  localparam int SMP_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_WAIT_SS
  } link_state_e;

  function automatic logic is_data(
    input logic [CHAN_W-1:0] tag
  );
    return tag != CHAN_NODATA;
  endfunction

endpackage

// File: rtl/adc_sample_link_sync_edge.sv
// Multi-flop synchroniser with registered
// rise/fall pulses for one asynchronous SPI pin.
module adc_sample_link_sync_edge
  import adc_sample_link_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_lvl;

  assign w_lvl = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{IDLE_VAL}};
      r_prev <= IDLE_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= w_lvl;
      r_rise <= w_lvl & ~r_prev;
      r_fall <= ~w_lvl & r_prev;
    end
  end

  assign o_level = w_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/adc_sample_link.sv
// SPI-slave ADC sample receiver; returns the
// consumer's requested channel on MISO each frame.
module adc_sample_link
  import adc_sample_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_ss,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  output logic                spi_miso,
  input  logic [CHAN_W-1:0]   channel,
  output logic                new_sample,
  output logic [SAMPLE_W-1:0] sample,
  output logic [CHAN_W-1:0]   sample_channel,
  output logic                frame_err
);

  logic w_ss_lvl;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_sck_lvl_unused;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_mosi_lvl;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  adc_sample_link_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_VAL   (1'b1)
  ) u_ss (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi_ss),
    .o_level(w_ss_lvl),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  adc_sample_link_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_VAL   (1'b0)
  ) u_sck (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi_sck),
    .o_level(w_sck_lvl_unused),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  adc_sample_link_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_VAL   (1'b0)
  ) u_mosi (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi_mosi),
    .o_level(w_mosi_lvl),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  link_state_e               r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [FRAME_BITS-1:0]     r_rx;
  logic [FRAME_BITS-1:0]     r_tx;
  logic                      r_miso;
  logic                      r_new;
  logic                      r_err;
  logic [SAMPLE_W-1:0]       r_sample;
  logic [CHAN_W-1:0]         r_chan;
  logic [SYNC_STAGES:0]      r_hold;
  logic                      r_armed;

  // The synchronisers restart at idle levels, so a pin
  // already low at reset release looks like an ss fall.
  // r_armed demands ss be seen high once the pipe settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_miso   <= 1'b0;
      r_new    <= 1'b0;
      r_err    <= 1'b0;
      r_sample <= '0;
      r_chan   <= '0;
      r_hold   <= '1;
      r_armed  <= 1'b0;
    end else begin
      r_new  <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= r_hold >> 1;
      if (~|r_hold && w_ss_lvl)
        r_armed <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall && r_armed) begin
            r_cnt   <= '0;
            r_miso  <= channel[CHAN_W-1];
            r_tx    <= {channel[CHAN_W-2:0],
                        {(FRAME_BITS-CHAN_W+1){1'b0}}};
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_err   <= 1'b1;
            r_rx    <= '0;
            r_state <= ST_IDLE;
          end else begin
            if (w_sck_rise) begin
              r_rx  <= {r_rx[FRAME_BITS-2:0], w_mosi_lvl};
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(FRAME_BITS - 1))
                r_state <= ST_DONE;
            end
            if (w_sck_fall) begin
              r_miso <= r_tx[FRAME_BITS-1];
              r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          if (is_data(r_rx[TAG_MSB:TAG_LSB])) begin
            r_sample <= r_rx[SMP_MSB:SMP_LSB];
            r_chan   <= r_rx[TAG_MSB:TAG_LSB];
            r_new    <= 1'b1;
          end
          r_state <= w_ss_rise ? ST_IDLE : ST_WAIT_SS;
        end
        ST_WAIT_SS: begin
          if (w_ss_rise)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_ss_lvl)
        r_miso <= 1'b0;
    end
  end

  assign spi_miso       = r_miso;
  assign new_sample     = r_new;
  assign frame_err      = r_err;
  assign sample         = r_sample;
  assign sample_channel = r_chan;

endmodule

// File: tb/tb_adc_sample_link.sv
// Self-checking bench for adc_sample_link: frame table,
// strobe scoreboard with latency, abort/reset/burst cases.
module tb_adc_sample_link;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic       frame_err;

  adc_sample_link #(.SYNC_STAGES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_ss        (spi_ss),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .channel       (channel),
    .new_sample    (new_sample),
    .sample        (sample),
    .sample_channel(sample_channel),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          half;
    bit          chk;
    logic [3:0]  chan;
    bit          exp_err;
    logic [9:0]  exp_smp;
    logic [3:0]  exp_ch;
  } vec_t;

  typedef struct {
    logic [9:0] smp;
    logic [3:0] ch;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  bit   prev_ns  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ns = 1'b0;
    end else begin
      if (new_sample) begin
        check("no_double_strobe", 32'(prev_ns), 0);
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_strobe: got sample %0h ch %0h expected none",
                   sample, sample_channel);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_sample", 32'(sample), 32'(e.smp));
          check("strobe_chan", 32'(sample_channel), 32'(e.ch));
          check("strobe_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (frame_err) err_seen++;
      prev_ns = new_sample;
    end
  end

  task automatic sck_bit(input logic b, input int half);
    spi_mosi = b;
    repeat (half) @(negedge clk);
    spi_sck = 1'b1;
    repeat (half) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send(input logic [15:0] d,
                      input int nbits,
                      input int half,
                      input bit chk,
                      input logic [15:0] mexp,
                      input int gap);
    spi_ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? d[15-i] : 1'($urandom);
      repeat (half) @(negedge clk);
      spi_sck = 1'b1;
      if (i == 15 && d[15:12] != 4'hF)
        sb.push_back('{d[9:0], d[15:12], cyc + 1 + S + 2});
      repeat (half - 1) @(negedge clk);
      if (chk && i < 16)
        check("miso_bit", 32'(spi_miso), 32'(mexp[15-i]));
      @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (half) @(negedge clk);
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    repeat (gap) @(negedge clk);
    if (chk) check("miso_idle", 32'(spi_miso), 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h32A5, 16, 6, 1'b1, 4'd3,  1'b0, 10'h2A5, 4'd3};
    vecs[1] = '{16'hF155, 16, 6, 1'b1, 4'd5,  1'b0, 10'h2A5, 4'd3};
    vecs[2] = '{16'h7123,  9, 3, 1'b0, 4'd0,  1'b1, 10'h2A5, 4'd3};
    vecs[3] = '{16'h13FF, 16, 6, 1'b1, 4'd10, 1'b0, 10'h3FF, 4'd1};
    vecs[4] = '{16'h0001, 20, 3, 1'b0, 4'd0,  1'b0, 10'h001, 4'd0};

    rst      = 1'b1;
    spi_ss   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    channel  = 4'd0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_new_sample", 32'(new_sample), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_chan", 32'(sample_channel), 0);
    check("rst_miso", 32'(spi_miso), 0);
    repeat (10) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      channel = vecs[v].chan;
      send(vecs[v].data, vecs[v].nbits, vecs[v].half,
           vecs[v].chk, {vecs[v].chan, 12'h000}, 8);
      if (vecs[v].exp_err) err_exp++;
      repeat (8) @(negedge clk);
      check("vec_sample", 32'(sample), 32'(vecs[v].exp_smp));
      check("vec_chan", 32'(sample_channel), 32'(vecs[v].exp_ch));
      check("vec_err_count", 32'(err_seen), 32'(err_exp));
    end

    channel = 4'd7;
    spi_ss  = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) sck_bit(1'(i & 1), 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_sample", 32'(sample), 0);
    check("midrst_chan", 32'(sample_channel), 0);
    check("midrst_miso", 32'(spi_miso), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) sck_bit(1'b1, 3);
    repeat (3) @(negedge clk);
    spi_ss = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_err", 32'(err_seen), 32'(err_exp));
    check("midrst_no_strobe", 32'(sample), 0);
    channel = 4'd2;
    send(16'h2100, 16, 6, 1'b1, 16'h2000, 8);
    repeat (8) @(negedge clk);
    check("post_rst_sample", 32'(sample), 32'h100);
    check("post_rst_chan", 32'(sample_channel), 32'd2);

    begin
      logic [15:0] d;
      for (int f = 0; f < 5; f++) begin
        d = {4'($urandom_range(0, 14)), 2'($urandom),
             10'($urandom)};
        send(d, 16, 2, 1'b0, 16'h0, S + 2);
      end
      repeat (20) @(negedge clk);
      check("burst_last_sample", 32'(sample), 32'(d[9:0]));
      check("burst_last_chan", 32'(sample_channel), 32'(d[15:12]));
    end

    check("sb_drained", 32'(sb.size()), 0);
    check("final_err_count", 32'(err_seen), 32'(err_exp));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
